// File: rtl/io_ctrl_multi.sv
// Memory-mapped IO controller: debounced keys with sticky edge flags,
// LED register with per-bit blink, and a maskable level interrupt.
module io_ctrl_multi #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
    parameter int          N_KEYS    = 4,
    parameter int          LED_W     = 16,
    parameter int          DB_CYCLES = 100000,
    parameter logic [31:0] BLINK_RST = 32'd25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wtData,
    output logic [31:0]       rdData,
    input  logic [N_KEYS-1:0] key,
    output logic [LED_W-1:0]  led,
    output logic              irq
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [31:0]       off;
    logic [2:0]        idx;
    logic              hit;
    logic              wr;
    logic [N_KEYS-1:0] key_m;
    logic [N_KEYS-1:0] key_s;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_edge;
    logic [N_KEYS-1:0] key_rise;
    logic [N_KEYS-1:0] irq_en;
    logic [LED_W-1:0]  led_data;
    logic [LED_W-1:0]  led_blink;
    logic [31:0]       blink_div;
    logic [31:0]       blink_cnt;
    logic              phase;

    // Offset decode: word-aligned, six registers starting at BASE_ADDR
    assign off = addr - BASE_ADDR;
    assign idx = off[4:2];
    assign hit = (off[31:5] == '0) && (off[1:0] == 2'b00) && (idx <= 3'd5);
    assign wr  = ce && we && hit;

    // Combinational read mux, zero when not a mapped read
    always_comb begin
        rdData = '0;
        if (ce && !we && hit) begin
            unique case (idx)
                3'd0: rdData[N_KEYS-1:0] = key_state;
                3'd1: rdData[N_KEYS-1:0] = key_edge;
                3'd2: rdData[LED_W-1:0]  = led_data;
                3'd3: rdData[LED_W-1:0]  = led_blink;
                3'd4: rdData             = blink_div;
                3'd5: rdData[N_KEYS-1:0] = irq_en;
                default: rdData = '0;
            endcase
        end
    end

    // Two-flop synchroniser for the raw key inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m <= '0;
            key_s <= '0;
        end else begin
            key_m <= key;
            key_s <= key_m;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_db
        logic [CW-1:0] cnt;

        assign key_rise[i] = key_s[i] && !key_state[i] && (cnt == DB_LAST);

        // Debounce: level must differ for DB_CYCLES cycles to be accepted
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt          <= '0;
                key_state[i] <= 1'b0;
            end else if (key_s[i] == key_state[i]) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt          <= '0;
                key_state[i] <= key_s[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Sticky rising-edge flags; a new edge beats a same-cycle W1C
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_edge <= '0;
        end else if (wr && idx == 3'd1) begin
            key_edge <= (key_edge & ~wtData[N_KEYS-1:0]) | key_rise;
        end else begin
            key_edge <= key_edge | key_rise;
        end
    end

    // Software-writable control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_data  <= '0;
            led_blink <= '0;
            irq_en    <= '0;
        end else if (wr) begin
            if (idx == 3'd2) led_data  <= wtData[LED_W-1:0];
            if (idx == 3'd3) led_blink <= wtData[LED_W-1:0];
            if (idx == 3'd5) irq_en    <= wtData[N_KEYS-1:0];
        end
    end

    // Blink timebase: divider register, down-counter and phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_div <= BLINK_RST;
            blink_cnt <= BLINK_RST;
            phase     <= 1'b1;
        end else if (wr && idx == 3'd4) begin
            blink_div <= wtData;
            blink_cnt <= wtData;
            phase     <= 1'b1;
        end else if (blink_div == '0) begin
            phase <= 1'b1;
        end else if (blink_cnt == '0) begin
            blink_cnt <= blink_div;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    // Registered LED drive with blinking bits blanked in the off phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_data & ~(led_blink & {LED_W{~phase}});
        end
    end

    assign irq = |(key_edge & irq_en);

endmodule
